regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised general-purpose register file for the pipelined CPU; next generation of the single-write/dual-read register file.
- Adds configurable data width and depth, posedge writeback, same-cycle write-to-read bypass and a per-register pending-write scoreboard.
- The decode stage uses the scoreboard to generate RAW-hazard stalls.
- Sits between the ID stage (reads, issue reservation) and the WB stage (writeback).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero: never written, never reserved, always reads 0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rf_ena  in  1  read enable; 0 forces rs_data/rt_data to 0 and rs_busy/rt_busy/stall to 0.
- rsc  in  ADDR_W  read port A index.
- rtc  in  ADDR_W  read port B index.
- rs_used  in  1  ID stage consumes port A this cycle.
- rt_used  in  1  ID stage consumes port B this cycle.
- rs_data  out  DATA_W  port A read data (combinational).
- rt_data  out  DATA_W  port B read data (combinational).
- rs_busy  out  1  port A register has an outstanding write.
- rt_busy  out  1  port B register has an outstanding write.
- stall  out  1  (rs_busy & rs_used) | (rt_busy & rt_used).
- iss_en  in  1  reserve destination iss_rd (instruction leaves ID).
- iss_rd  in  ADDR_W  destination index to reserve.
- wb_en  in  1  writeback strobe.
- wb_rd  in  ADDR_W  writeback index.
- wb_data  in  DATA_W  writeback data.
- busy_cnt  out  ADDR_W+1  number of registers currently reserved.

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, all busy bits = 0, busy_cnt = 0. Outputs are combinational from this state, so rs_data/rt_data = 0 while reset is held.
- Reset mid-operation discards every pending reservation; the first edge after rst_n rises behaves as a normal cycle.
- Write:
  - On rising clk with wb_en=1, reg[wb_rd] <= wb_data.
  - If ZERO_REG=1 and wb_rd=0, the write is ignored.
- Read (zero latency, combinational):
  - rs_data = bypass ? wb_data : reg[rsc], where bypass = wb_en & (wb_rd==rsc) & !(ZERO_REG & rsc==0). rt_data is identical with rtc.
  - Index 0 reads 0 when ZERO_REG=1.
- Scoreboard (busy[i] flops):
  - Set on rising clk when iss_en=1 and iss_rd valid (iss_rd!=0 when ZERO_REG=1).
  - Cleared on rising clk when wb_en=1 at wb_rd.
  - Same edge, same index, both set and clear: set wins (a newer producer is reserved).
  - Same edge, different indices: both take effect.
  - Set on an already-busy register: stays 1 (single-outstanding-producer model; the pipeline guarantees in-order writeback).
  - Clear on a non-busy register: no effect, no error.
- Busy outputs:
  - rs_busy = rf_ena & busy[rsc] & !(wb_en & wb_rd==rsc). Same-cycle writeback is visible through the bypass, so no stall is raised for it. rt_busy is identical with rtc.
  - stall is purely combinational; it does not gate iss_en internally. The ID stage must drop iss_en while stall=1.
- busy_cnt:
  - Registered; updated each edge by +1 on a set of a non-busy register and −1 on a clear of a busy register (net 0 when both).
  - Equals the popcount of busy[] at all times; never exceeds 2**ADDR_W − ZERO_REG.
- rf_ena=0 affects outputs only; writes and scoreboard updates still occur.

Test Plan:
- Reset → all reads 0, busy_cnt=0: hold rst_n=0, then read every index → 0. Write r3=0xDEADBEEF, assert rst_n=0 asynchronously mid-cycle → rs_data(rsc=3) reads 0 immediately.
- Write then read:
  - wb_en, wb_rd=5, wb_data=0x12345678, one edge; then rsc=5, rtc=5 → both 0x12345678.
  - wb_rd=0 with 0xFFFFFFFF → rsc=0 reads 0.
- Bypass: reg7=0x11 stored; same cycle wb_en, wb_rd=7, wb_data=0x22, rsc=7 → rs_data=0x22 before the edge, and rs_busy=0 even if busy[7]=1.
- Scoreboard stall:
  - iss_en, iss_rd=9, one edge → busy_cnt=1; rsc=9, rs_used=1 → stall=1.
  - rt_used=0 with rtc=9 → rt_busy=1 but stall driven only by port A.
  - wb_en, wb_rd=9 → stall=0 that cycle; after the edge busy_cnt=0.
- Simultaneous set/clear:
  - busy[4]=1; same edge iss_rd=4 and wb_rd=4 → busy[4] stays 1, busy_cnt unchanged.
  - iss_rd=6, wb_rd=4 on the same edge → busy[6]=1, busy[4]=0, busy_cnt unchanged.
- rf_ena=0: with busy[2]=1 and reg2=0xA5 → rs_data=0, rs_busy=0, stall=0; a write to r2 still lands (reads 0xA5→new value once rf_ena=1).

Source files
------------

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
//   General-purpose register file for the pipelined CPU, with a pending-write
//   scoreboard. It has one writeback port and two combinational read ports.
//   A write that lands in the same cycle as a read of the same register is
//   bypassed to the reader. Each register has a busy bit. The ID stage sets a
//   busy bit when an instruction reserves that register as its destination,
//   and the WB stage clears it on writeback. The ID stage uses the busy bits
//   to generate RAW-hazard stalls.
//
// Parameters
//   DATA_W   register width in bits
//   ADDR_W   register index width; depth = 2**ADDR_W
//   ZERO_REG 1 = register 0 reads 0 and is never written or reserved
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   rf_ena             read enable; 0 forces read data, busy and stall to 0
//   rsc, rtc           read port A / B indices
//   rs_used, rt_used   ID stage consumes port A / B this cycle
//   rs_data, rt_data   combinational read data with writeback bypass
//   rs_busy, rt_busy   selected register has an outstanding write
//   stall              RAW hazard on a consumed port
//   iss_en, iss_rd     reserve destination register iss_rd
//   wb_en, wb_rd,
//   wb_data            writeback strobe, index and data
//   busy_cnt           number of registers currently reserved
// ---------------------------------------------------------------------------
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rf_ena,
  input  logic [ADDR_W-1:0] rsc,
  input  logic [ADDR_W-1:0] rtc,
  input  logic              rs_used,
  input  logic              rt_used,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              stall,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int   DEPTH   = 2 ** ADDR_W;
  localparam int   CNT_W   = ADDR_W + 1;
  localparam logic HW_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;

  logic wrValid, setValid, cntInc, cntDec;
  logic rsIsZero, rtIsZero, rsBypass, rtBypass;

  // When register 0 is hardwired, writes and reservations aimed at it are
  // dropped here, so the storage and scoreboard never hold state for it.
  assign wrValid  = wb_en  && !(HW_ZERO && (wb_rd  == '0));
  assign setValid = iss_en && !(HW_ZERO && (iss_rd == '0));

  // Register storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wrValid) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  // Apply the clear first and the set second. When both hit the same index,
  // the reservation from the newer producer survives.
  always_comb begin
    busy_d = busy_q;
    if (wb_en) begin
      busy_d[wb_rd] = 1'b0;
    end
    if (setValid) begin
      busy_d[iss_rd] = 1'b1;
    end
  end

  // The counter tracks the popcount of busy_q incrementally. A set counts only
  // if the register was idle. A clear counts only if the register was busy
  // and is not re-reserved on the same edge.
  always_comb begin
    cntInc     = setValid && !busy_q[iss_rd];
    cntDec     = wb_en && busy_q[wb_rd] && !(setValid && (iss_rd == wb_rd));
    busy_cnt_d = busy_cnt_q;
    if (cntInc && !cntDec) begin
      busy_cnt_d = busy_cnt_q + CNT_W'(1);
    end else if (cntDec && !cntInc) begin
      busy_cnt_d = busy_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  // The bypass is suppressed for register 0. A write to r0 is ignored, so
  // forwarding its data would be wrong.
  assign rsIsZero = HW_ZERO && (rsc == '0);
  assign rtIsZero = HW_ZERO && (rtc == '0);
  assign rsBypass = wb_en && (wb_rd == rsc) && !rsIsZero;
  assign rtBypass = wb_en && (wb_rd == rtc) && !rtIsZero;

  always_comb begin
    rs_data = '0;
    if (rf_ena) begin
      if (rsBypass) begin
        rs_data = wb_data;
      end else if (!rsIsZero) begin
        rs_data = regs_q[rsc];
      end
    end
  end

  always_comb begin
    rt_data = '0;
    if (rf_ena) begin
      if (rtBypass) begin
        rt_data = wb_data;
      end else if (!rtIsZero) begin
        rt_data = regs_q[rtc];
      end
    end
  end

  // A register being written back this cycle is served by the bypass, so it
  // is not reported busy. This avoids a needless stall.
  assign rs_busy = rf_ena && busy_q[rsc] && !(wb_en && (wb_rd == rsc));
  assign rt_busy = rf_ena && busy_q[rtc] && !(wb_en && (wb_rd == rtc));
  assign stall   = (rs_busy && rs_used) || (rt_busy && rt_used);

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb
//   Self-checking bench for regfile_sb (DATA_W=32, ADDR_W=5, ZERO_REG=1).
//   It runs directed scenarios and then a randomized phase. Both are checked
//   against a behavioural model made of an array of register values and an
//   array of pending-write flags. The model computes the expected reserved
//   count as a popcount.
// ---------------------------------------------------------------------------
module tb_regfile_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rf_ena;
  logic [AW-1:0] rsc, rtc;
  logic          rs_used, rt_used;
  logic [DW-1:0] rs_data, rt_data;
  logic          rs_busy, rt_busy, stall;
  logic          iss_en;
  logic [AW-1:0] iss_rd;
  logic          wb_en;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic [AW:0]   busy_cnt;

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] mReg  [DEPTH];
  bit            mBusy [DEPTH];

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .rf_ena(rf_ena),
    .rsc(rsc), .rtc(rtc), .rs_used(rs_used), .rt_used(rt_used),
    .rs_data(rs_data), .rt_data(rt_data),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .stall(stall),
    .iss_en(iss_en), .iss_rd(iss_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model
  function automatic logic [DW-1:0] expRead(logic [AW-1:0] idx);
    if (!rf_ena) return '0;
    if (idx == 0) return '0;
    if (wb_en && wb_rd == idx) return wb_data;
    return mReg[idx];
  endfunction

  function automatic logic expBusy(logic [AW-1:0] idx);
    return rf_ena && mBusy[idx] && !(wb_en && wb_rd == idx);
  endfunction

  function automatic int expCount();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += mBusy[i] ? 1 : 0;
    return n;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) begin
      mReg[i]  = '0;
      mBusy[i] = 1'b0;
    end
  endtask

  task automatic modelEdge();
    if (!rst_n) begin
      modelReset();
    end else begin
      if (wb_en && wb_rd != 0) mReg[wb_rd] = wb_data;
      if (wb_en) mBusy[wb_rd] = 1'b0;
      if (iss_en && iss_rd != 0) mBusy[iss_rd] = 1'b1;
    end
  endtask

  // Checking
  task automatic cmp(string tag, logic [63:0] obs, logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(string tag);
    logic eRs, eRt;
    eRs = expBusy(rsc);
    eRt = expBusy(rtc);
    cmp({tag, ".rs_data"},  64'(rs_data),  64'(expRead(rsc)));
    cmp({tag, ".rt_data"},  64'(rt_data),  64'(expRead(rtc)));
    cmp({tag, ".rs_busy"},  64'(rs_busy),  64'(eRs));
    cmp({tag, ".rt_busy"},  64'(rt_busy),  64'(eRt));
    cmp({tag, ".stall"},    64'(stall),    64'((eRs && rs_used) || (eRt && rt_used)));
    cmp({tag, ".busy_cnt"}, 64'(busy_cnt), 64'(expCount()));
  endtask

  // Stimulus helpers
  task automatic applyStimulus(logic ena, logic [AW-1:0] a, logic [AW-1:0] b,
                               logic ua, logic ub, logic ie, logic [AW-1:0] ird,
                               logic we, logic [AW-1:0] wrd, logic [DW-1:0] wd);
    rf_ena = ena; rsc = a; rtc = b; rs_used = ua; rt_used = ub;
    iss_en = ie; iss_rd = ird; wb_en = we; wb_rd = wrd; wb_data = wd;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic stepClock();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  initial begin
    modelReset();
    rst_n = 1'b0;
    idle();

    // Reset state: every index reads 0
    repeat (2) stepClock();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, AW'(i), AW'(DEPTH - 1 - i), 1, 1, 0, 0, 0, 0, '0);
      cmp("reset.rs_data", 64'(rs_data), 64'h0);
      cmp("reset.rt_data", 64'(rt_data), 64'h0);
    end
    cmp("reset.busy_cnt", 64'(busy_cnt), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    stepClock();

    // Write r3 while reserving r10, then an asynchronous reset mid-cycle
    applyStimulus(1, 0, 0, 0, 0, 1, 10, 1, 3, 32'hDEADBEEF);
    stepClock();
    applyStimulus(1, 3, 10, 0, 0, 0, 0, 0, 0, '0);
    cmp("wr3.rs_data", 64'(rs_data), 64'hDEADBEEF);
    cmp("wr3.busy_cnt", 64'(busy_cnt), 64'h1);
    checkOutput("wr3");
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    cmp("asyncrst.rs_data", 64'(rs_data), 64'h0);
    cmp("asyncrst.busy_cnt", 64'(busy_cnt), 64'h0);
    checkOutput("asyncrst");
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    stepClock();
    checkOutput("postrst");

    // Write then read r5; writes to r0 are ignored and not bypassed
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 5, 32'h12345678);
    stepClock();
    applyStimulus(1, 5, 5, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF);
    cmp("rd5.rs_data", 64'(rs_data), 64'h12345678);
    cmp("rd5.rt_data", 64'(rt_data), 64'h12345678);
    stepClock();
    applyStimulus(1, 0, 5, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF);
    cmp("r0byp.rs_data", 64'(rs_data), 64'h0);
    checkOutput("r0byp");
    stepClock();
    idle();
    cmp("r0.rs_data", 64'(rs_data), 64'h0);

    // Bypass with r7 busy
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 7, 32'h11);
    stepClock();
    applyStimulus(1, 0, 0, 0, 0, 1, 7, 0, 0, '0);
    stepClock();
    applyStimulus(1, 7, 7, 1, 0, 0, 0, 0, 0, '0);
    cmp("b7pre.rs_data", 64'(rs_data), 64'h11);
    cmp("b7pre.stall", 64'(stall), 64'h1);
    applyStimulus(1, 7, 7, 1, 1, 0, 0, 1, 7, 32'h22);
    cmp("byp.rs_data", 64'(rs_data), 64'h22);
    cmp("byp.rs_busy", 64'(rs_busy), 64'h0);
    cmp("byp.stall", 64'(stall), 64'h0);
    checkOutput("byp");
    stepClock();
    idle();
    cmp("byp.busy_cnt", 64'(busy_cnt), 64'h0);

    // Scoreboard stall on r9
    applyStimulus(1, 0, 0, 0, 0, 1, 9, 0, 0, '0);
    stepClock();
    applyStimulus(1, 9, 0, 1, 0, 0, 0, 0, 0, '0);
    cmp("sb9.busy_cnt", 64'(busy_cnt), 64'h1);
    cmp("sb9.stall", 64'(stall), 64'h1);
    applyStimulus(1, 0, 9, 0, 0, 0, 0, 0, 0, '0);
    cmp("sb9rt.rt_busy", 64'(rt_busy), 64'h1);
    cmp("sb9rt.stall", 64'(stall), 64'h0);
    applyStimulus(1, 9, 9, 1, 1, 0, 0, 1, 9, 32'h99);
    cmp("sb9wb.stall", 64'(stall), 64'h0);
    checkOutput("sb9wb");
    stepClock();
    idle();
    cmp("sb9clr.busy_cnt", 64'(busy_cnt), 64'h0);

    // Simultaneous set/clear
    applyStimulus(1, 0, 0, 0, 0, 1, 4, 0, 0, '0);
    stepClock();
    applyStimulus(1, 0, 0, 0, 0, 1, 4, 1, 4, 32'h44);
    stepClock();
    applyStimulus(1, 4, 0, 1, 0, 0, 0, 0, 0, '0);
    cmp("same.busy_cnt", 64'(busy_cnt), 64'h1);
    cmp("same.rs_busy", 64'(rs_busy), 64'h1);
    applyStimulus(1, 0, 0, 0, 0, 1, 6, 1, 4, 32'h45);
    stepClock();
    applyStimulus(1, 6, 4, 1, 1, 0, 0, 0, 0, '0);
    cmp("diff.busy_cnt", 64'(busy_cnt), 64'h1);
    cmp("diff.rs_busy", 64'(rs_busy), 64'h1);
    cmp("diff.rt_busy", 64'(rt_busy), 64'h0);
    checkOutput("diff");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 6, 32'h66);
    stepClock();

    // Read enable low gates outputs only
    applyStimulus(1, 0, 0, 0, 0, 1, 2, 1, 2, 32'hA5);
    stepClock();
    applyStimulus(0, 2, 2, 1, 1, 0, 0, 0, 0, '0);
    cmp("ena0.rs_data", 64'(rs_data), 64'h0);
    cmp("ena0.rs_busy", 64'(rs_busy), 64'h0);
    cmp("ena0.stall", 64'(stall), 64'h0);
    checkOutput("ena0");
    applyStimulus(0, 2, 2, 1, 1, 0, 0, 1, 2, 32'h5A);
    stepClock();
    applyStimulus(1, 2, 2, 1, 1, 0, 0, 0, 0, '0);
    cmp("ena1.rs_data", 64'(rs_data), 64'h5A);
    cmp("ena1.rs_busy", 64'(rs_busy), 64'h0);
    checkOutput("ena1");

    // Randomized phase on a small index window to provoke collisions
    for (int n = 0; n < 500; n++) begin
      applyStimulus(($urandom_range(0, 7) != 0),
                    AW'($urandom_range(0, 9)), AW'($urandom_range(0, 9)),
                    1'($urandom), 1'($urandom),
                    1'($urandom), AW'($urandom_range(0, 9)),
                    1'($urandom), AW'($urandom_range(0, 9)), $urandom);
      checkOutput("rnd");
      stepClock();
    end
    // Fill every register with reservations to exercise the full count
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 1, AW'(i), 0, 0, '0);
      stepClock();
    end
    idle();
    cmp("full.busy_cnt", 64'(busy_cnt), 64'd31);
    checkOutput("full");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
